// File: rtl/smi_frame_arbiter.sv
// smi_frame_arbiter: frame-locked round-robin arbiter sharing one SMI request channel between NumPorts requesters
module smi_frame_arbiter #(
    parameter int NumPorts      = 4,
    parameter int PortIndexSize = 2,
    parameter int DataIndexSize = 4,
    parameter int DataWidth     = (1 << DataIndexSize) * 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NumPorts-1:0]           smiInReady,
    input  logic [NumPorts*8-1:0]         smiInEofc,
    input  logic [NumPorts*DataWidth-1:0] smiInData,
    output logic [NumPorts-1:0]           smiInStop,
    output logic                          smiOutReady,
    output logic [7:0]                    smiOutEofc,
    output logic [DataWidth-1:0]          smiOutData,
    input  logic                          smiOutStop,
    output logic                          grantValid,
    output logic [PortIndexSize-1:0]      grantIndex
);
    typedef enum logic {Idle, Forward} stateT;
    stateT state, nextState;
    logic [PortIndexSize-1:0] lastGrant, nextLastGrant, nextGrantIndex, pick;
    logic nextGrantValid, outFull, accept, grantReady;
    logic [7:0] grantEofc;
    logic [DataWidth-1:0] grantData;
    assign outFull    = smiOutReady & smiOutStop;
    assign grantReady = smiInReady[grantIndex];
    assign grantEofc  = smiInEofc[8*grantIndex +: 8];
    assign grantData  = smiInData[DataWidth*grantIndex +: DataWidth];
    assign accept     = (state == Forward) & grantReady & ~outFull;
    // search from farthest to nearest so the port right after lastGrant wins
    always_comb begin
        pick = lastGrant;
        for (int k = NumPorts; k >= 1; k--)
            if (smiInReady[(int'(lastGrant) + k) % NumPorts])
                pick = PortIndexSize'((int'(lastGrant) + k) % NumPorts);
    end
    // only the locked port sees the output-stage backpressure; everyone else is stopped
    always_comb begin
        smiInStop = '1;
        for (int i = 0; i < NumPorts; i++)
            smiInStop[i] = (state == Forward && grantIndex == PortIndexSize'(i)) ? outFull : 1'b1;
    end
    // next-state: lock a port in Idle, release it when its final flit is taken
    always_comb begin
        nextState      = state;
        nextGrantIndex = grantIndex;
        nextGrantValid = grantValid;
        nextLastGrant  = lastGrant;
        if (state == Idle) begin
            if (|smiInReady) begin
                nextState      = Forward;
                nextGrantIndex = pick;
                nextGrantValid = 1'b1;
            end
        end else if (accept && grantEofc != 8'd0) begin
            nextState      = Idle;
            nextGrantValid = 1'b0;
            nextLastGrant  = grantIndex;
        end
    end
    // state and grant registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= Idle;
            grantValid <= 1'b0;
            grantIndex <= '0;
            lastGrant  <= PortIndexSize'(NumPorts - 1);
        end else begin
            state      <= nextState;
            grantValid <= nextGrantValid;
            grantIndex <= nextGrantIndex;
            lastGrant  <= nextLastGrant;
        end
    end
    // output valid reloads whenever the stage is not halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            smiOutReady <= 1'b0;
        else if (!outFull)
            smiOutReady <= (state == Forward) & grantReady;
    end
    // output payload follows the valid without reset
    always_ff @(posedge clk) begin
        if (!outFull) begin
            smiOutEofc <= grantEofc;
            smiOutData <= grantData;
        end
    end
endmodule

// File: tb/tb_smi_frame_arbiter.sv
// tb_smi_frame_arbiter: scoreboard bench for the frame-locked round-robin arbiter
module tb_smi_frame_arbiter;
    localparam int NumPorts  = 4;
    localparam int DataWidth = 128;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NumPorts-1:0] smiInReady, smiInStop;
    logic [NumPorts*8-1:0] smiInEofc;
    logic [NumPorts*DataWidth-1:0] smiInData;
    logic smiOutReady, smiOutStop, grantValid;
    logic [7:0] smiOutEofc;
    logic [DataWidth-1:0] smiOutData;
    logic [1:0] grantIndex;
    logic [135:0] srcMem [NumPorts][32];
    int head [NumPorts];
    int tail [NumPorts];
    logic [NumPorts-1:0] en;
    logic [135:0] sb [$];
    int expGrant [$];
    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int lastEofcCycle;
    logic prevGv, outStop, bubbleMode;
    logic [DataWidth-1:0] frozen;

    smi_frame_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .smiInReady(smiInReady), .smiInEofc(smiInEofc), .smiInData(smiInData), .smiInStop(smiInStop),
        .smiOutReady(smiOutReady), .smiOutEofc(smiOutEofc), .smiOutData(smiOutData), .smiOutStop(smiOutStop),
        .grantValid(grantValid), .grantIndex(grantIndex)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [135:0] got, input logic [135:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic addFrame(input int p, input int n, input int id, input logic [7:0] lastEofc);
        for (int f = 0; f < n; f++) begin
            srcMem[p][tail[p]] = {(f == n - 1) ? lastEofc : 8'd0, {8{p[3:0], id[3:0], f[7:0]}}};
            tail[p]++;
        end
    endtask

    task automatic drive();
        logic [135:0] w;
        for (int i = 0; i < NumPorts; i++) begin
            smiInReady[i] = en[i] && head[i] < tail[i];
            w = smiInReady[i] ? srcMem[i][head[i]] : '0;
            smiInEofc[8*i +: 8] = w[135:128];
            smiInData[DataWidth*i +: DataWidth] = w[127:0];
        end
        smiOutStop = outStop;
    endtask

    task automatic process();
        logic [135:0] e;
        if (smiOutReady && !smiOutStop) begin
            if (sb.size() == 0) checkVal("sbUnderflow", 1, 0);
            else begin
                e = sb.pop_front();
                checkVal("flitEofc", smiOutEofc, e[135:128]);
                checkVal("flitData", smiOutData, e[127:0]);
            end
            if (bubbleMode) begin
                if (smiOutEofc == 8'd0 && lastEofcCycle >= 0) checkVal("bubble", cycle - lastEofcCycle, 2);
                if (smiOutEofc != 8'd0) lastEofcCycle = cycle;
            end
        end
        if (grantValid && !prevGv) begin
            if (expGrant.size() == 0) checkVal("grantExtra", 1, 0);
            else checkVal("grantOrder", grantIndex, expGrant.pop_front());
        end
        prevGv = grantValid;
        for (int i = 0; i < NumPorts; i++) begin
            if (!grantValid || grantIndex != 2'(i)) checkVal("stopOther", smiInStop[i], 1);
            if (smiInReady[i] && !smiInStop[i]) begin
                sb.push_back(srcMem[i][head[i]]);
                head[i]++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        cycle++;
        process();
    endtask

    function automatic logic pending();
        for (int i = 0; i < NumPorts; i++) if (head[i] < tail[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || pending() || grantValid || smiOutReady) && n < 300) begin
            step();
            n++;
        end
        checkVal({tag, "Timeout"}, n < 300, 1);
        checkVal({tag, "Lost"}, sb.size(), 0);
        checkVal({tag, "Grants"}, expGrant.size(), 0);
    endtask

    task automatic waitGrant();
        int n = 0;
        while (!grantValid && n < 20) begin
            step();
            n++;
        end
        checkVal("grantWait", grantValid, 1);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        en = '1;
        outStop = 1'b0;
        bubbleMode = 1'b0;
        prevGv = 1'b0;
        sb.delete();
        expGrant.delete();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rstOutReady", smiOutReady, 0);
        checkVal("rstGrantValid", grantValid, 0);
        checkVal("rstGrantIndex", grantIndex, 0);
        checkVal("rstInStop", smiInStop, 4'hF);
        rst_n = 1'b1;
    endtask

    initial begin
        doReset();
        addFrame(0, 3, 1, 8'd16);
        expGrant.push_back(0);
        step();
        checkVal("t1c0Gv", grantValid, 0);
        step();
        checkVal("t1c1Gv", grantValid, 1);
        checkVal("t1c1Ready", smiOutReady, 0);
        step();
        checkVal("t1c2Ready", smiOutReady, 1);
        step();
        checkVal("t1c3Ready", smiOutReady, 1);
        step();
        checkVal("t1c4Ready", smiOutReady, 1);
        checkVal("t1c4Eofc", smiOutEofc, 16);
        checkVal("t1c4Gv", grantValid, 0);
        step();
        checkVal("t1c5Ready", smiOutReady, 0);
        drain("t1");

        doReset();
        for (int p = 0; p < NumPorts; p++) begin
            addFrame(p, 2, 2, 8'(p + 1));
            expGrant.push_back(p);
        end
        bubbleMode = 1'b1;
        lastEofcCycle = -1;
        drain("t2");
        bubbleMode = 1'b0;

        addFrame(2, 1, 3, 8'd8);
        expGrant.push_back(2);
        drain("t3a");
        addFrame(1, 2, 3, 8'd5);
        addFrame(3, 2, 3, 8'd7);
        expGrant.push_back(3);
        expGrant.push_back(1);
        drain("t3b");

        addFrame(0, 4, 4, 8'd16);
        addFrame(1, 2, 4, 8'd9);
        expGrant.push_back(0);
        expGrant.push_back(1);
        for (int n = 0; n < 10 && !smiOutReady; n++) step();
        step();
        outStop = 1'b1;
        step();
        frozen = smiOutData;
        checkVal("stallReady", smiOutReady, 1);
        checkVal("stallStop0", smiInStop, 4'hF);
        repeat (4) begin
            step();
            checkVal("stallData", smiOutData, frozen);
            checkVal("stallStop", smiInStop, 4'hF);
        end
        outStop = 1'b0;
        drain("t4");

        addFrame(2, 4, 5, 8'd12);
        addFrame(1, 2, 5, 8'd3);
        expGrant.push_back(2);
        expGrant.push_back(1);
        waitGrant();
        step();
        en[2] = 1'b0;
        repeat (4) begin
            step();
            checkVal("holdGv", grantValid, 1);
            checkVal("holdIdx", grantIndex, 2);
        end
        en[2] = 1'b1;
        drain("t5");

        addFrame(1, 4, 6, 8'd16);
        expGrant.push_back(1);
        waitGrant();
        step();
        step();
        checkVal("preRstReady", smiOutReady, 1);
        #2 rst_n = 1'b0;
        #1;
        checkVal("asyncReady", smiOutReady, 0);
        checkVal("asyncGv", grantValid, 0);
        doReset();
        addFrame(0, 2, 7, 8'd2);
        addFrame(2, 2, 7, 8'd2);
        expGrant.push_back(0);
        expGrant.push_back(2);
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
